sram_model_2p: RTL and testbench
================================

SRAM_MODEL_2P -- requirements
Module: sram_model_2p

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 518, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words (any value >= 2).
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, address width; must be >= ceil(log2(DEPTH)).
REQ-004 SHALL have parameter MASK_GRAN, default 8, data bits per write-mask bit; MASK_W = ceil(DATA_WIDTH/MASK_GRAN), so the last lane may be partial.
REQ-005 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal range 1..4.
REQ-006 SHALL have parameter BYPASS, default 1; 1 = write-first on collision, 0 = read-first.
REQ-007 SHALL have port inst_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port inst_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port inst_wr_cs_n, input, 1 bit: active-low write request.
REQ-010 SHALL have port inst_wr_addr, input, ADDR_WIDTH bits: write address.
REQ-011 SHALL have port inst_wr_data, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port inst_wr_mask, input, MASK_W bits: 1 = lane written.
REQ-013 SHALL have port inst_rd_cs_n, input, 1 bit: active-low read request.
REQ-014 SHALL have port inst_rd_addr, input, ADDR_WIDTH bits: read address.
REQ-015 SHALL have port inst_init_start, input, 1 bit: pulse that starts a zero-fill of the array.
REQ-016 SHALL have port data_out_inst, output, DATA_WIDTH bits: read data.
REQ-017 SHALL have port data_out_vld, output, 1 bit: one-cycle strobe marking new read data.
REQ-018 SHALL have port init_busy, output, 1 bit: high while the zero-fill runs.

Function
REQ-019 SHALL implement states INIT and IDLE; INIT writes zero to address cnt each cycle, cnt 0..DEPTH-1, then enters IDLE; the fill takes exactly DEPTH cycles.
REQ-020 SHALL enter INIT from IDLE when inst_init_start=1; inst_init_start SHALL be ignored while in INIT.
REQ-021 SHALL drive init_busy=1 exactly while in INIT, and SHALL ignore read and write requests while in INIT (no array update, no data_out_vld).
REQ-022 SHALL in IDLE accept a write when inst_wr_cs_n=0, updating only the lanes whose mask bit is 1.
REQ-023 SHALL in IDLE accept a read when inst_rd_cs_n=0; read and write SHALL be accepted independently in the same cycle.
REQ-024 SHALL present a read result on data_out_inst, with data_out_vld=1, exactly RD_LATENCY cycles after the accepting edge, fully pipelined (one read per cycle).
REQ-025 SHALL hold data_out_inst at its last value when no result is due, and SHALL drive data_out_vld=0 in those cycles.
REQ-026 SHALL, on a same-cycle read and write to the same address, return per lane: when BYPASS=1, new data for masked lanes and old data for unmasked lanes; when BYPASS=0, old data for all lanes.
REQ-027 SHALL ignore a write to an address >= DEPTH, and SHALL return all-zero data (data_out_vld still 1) for a read of an address >= DEPTH.
REQ-028 SHALL, when a write is accepted and then a read of the same address is accepted the next cycle, return the written data regardless of RD_LATENCY.

Reset
REQ-029 SHALL on inst_rst_n=0 asynchronously clear data_out_inst, data_out_vld, the read pipeline and cnt, and force state INIT with init_busy=1.
REQ-030 SHALL NOT reset the array asynchronously; after reset release it SHALL auto-fill to zero via INIT, and a reset during INIT SHALL restart the fill from address 0.

Structure
REQ-031 SHALL place the state encoding (INIT, IDLE) and the MASK_W derivation function in the shared memory-controller package.
REQ-032 SHALL have exactly one sub-module, sram_rd_pipe: a RD_LATENCY-deep data/valid shift register with asynchronous reset.

Verification
REQ-033 Bench SHALL check reset release: init_busy=1 for exactly 64 cycles, then 0; a read of address 5 returns 0 with vld.
REQ-034 Bench SHALL check write 0x...AA to address 3 with full mask, then read address 3 at RD_LATENCY=3: data appears with vld exactly 3 cycles after the read edge.
REQ-035 Bench SHALL check masked write, mask bit 0 only, data 0xFF into a word holding 0x1234: readback is 0x12FF.
REQ-036 Bench SHALL check a collision at address 7 (old 0x11, new 0x22, full mask): BYPASS=1 returns 0x22 and BYPASS=0 returns 0x11.
REQ-037 Bench SHALL check DEPTH=50 with a write to address 60: the array is unchanged and a read of address 60 returns 0 with vld.
REQ-038 Bench SHALL check inst_rst_n asserted at fill cycle 20: outputs are zero at once, and after release init_busy lasts a full DEPTH cycles.

Source files
------------

// File: rtl/sram_model_2p_pkg.sv
// Shared memory-controller definitions: controller state encoding and the
// write-mask width helper used to size the per-lane byte-enable port.
package sram_model_2p_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Number of mask lanes for a word; the top lane may be narrower than the
  // granule when the word width is not a multiple of it.
  function automatic int calc_mask_w(input int data_width, input int mask_gran);
    return (data_width + mask_gran - 1) / mask_gran;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-result delay line: LATENCY stages of data/valid. Data registers only
// load when their incoming valid is set, so the final stage holds the last
// delivered word between results.
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 518,
  parameter int LATENCY    = 1
) (
  input  logic                  inst_clk,
  input  logic                  inst_rst_n,
  input  logic                  rd_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  pipe_vld,
  output logic [DATA_WIDTH-1:0] pipe_data
);

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic                  vld_src;
      logic [DATA_WIDTH-1:0] data_src;
      logic                  vld_reg;
      logic [DATA_WIDTH-1:0] data_reg;

      if (gi == 0) begin : g_head
        assign vld_src  = rd_vld;
        assign data_src = rd_data;
      end else begin : g_tail
        assign vld_src  = g_stage[gi-1].vld_reg;
        assign data_src = g_stage[gi-1].data_reg;
      end

      // one pipeline stage: valid always shifts, data only moves with a valid
      always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
          vld_reg  <= 1'b0;
          data_reg <= '0;
        end else begin
          vld_reg <= vld_src;
          if (vld_src) begin
            data_reg <= data_src;
          end
        end
      end
    end
  endgenerate

  assign pipe_vld  = g_stage[LATENCY-1].vld_reg;
  assign pipe_data = g_stage[LATENCY-1].data_reg;

endmodule

// File: rtl/sram_model_2p.sv
// Two-port (one write, one read) SRAM model with per-lane write mask,
// configurable read latency, write-first/read-first collision handling and a
// self-running zero-fill after reset or on request.
module sram_model_2p
  import sram_model_2p_pkg::*;
#(
  parameter int DATA_WIDTH = 518,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int MASK_GRAN  = 8,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic                                           inst_clk,
  input  logic                                           inst_rst_n,
  input  logic                                           inst_wr_cs_n,
  input  logic [ADDR_WIDTH-1:0]                          inst_wr_addr,
  input  logic [DATA_WIDTH-1:0]                          inst_wr_data,
  input  logic [calc_mask_w(DATA_WIDTH, MASK_GRAN)-1:0]  inst_wr_mask,
  input  logic                                           inst_rd_cs_n,
  input  logic [ADDR_WIDTH-1:0]                          inst_rd_addr,
  input  logic                                           inst_init_start,
  output logic [DATA_WIDTH-1:0]                          data_out_inst,
  output logic                                           data_out_vld,
  output logic                                           init_busy
);

  localparam int                MASK_W   = calc_mask_w(DATA_WIDTH, MASK_GRAN);
  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  CNT_LAST = IDX_W'(DEPTH - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [IDX_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  cnt_next;

  logic              idle;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic              rd_ok;
  logic              hit;
  logic [IDX_W-1:0]  mem_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign idle        = (state_reg == ST_IDLE);
  assign init_busy   = (state_reg == ST_INIT);
  assign wr_in_range = ({1'b0, inst_wr_addr} < DEPTH_A);
  assign rd_in_range = ({1'b0, inst_rd_addr} < DEPTH_A);
  assign wr_ok       = idle && !inst_wr_cs_n && wr_in_range;
  assign rd_ok       = idle && !inst_rd_cs_n;
  assign hit         = wr_ok && (inst_wr_addr == inst_rd_addr);
  // The fill walks cnt; otherwise the write port follows the request.
  assign mem_idx     = idle ? inst_wr_addr[IDX_W-1:0] : cnt_reg;
  assign rd_idx      = inst_rd_addr[IDX_W-1:0];

  // state and fill-counter register
  always_ff @(posedge inst_clk or negedge inst_rst_n) begin
    if (!inst_rst_n) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // next state: fill runs cnt 0..DEPTH-1 then idles; start ignored while filling
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_IDLE: begin
        if (inst_init_start) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // One narrow array per mask lane so each lane has its own write enable.
  genvar gi;
  generate
    for (gi = 0; gi < MASK_W; gi++) begin : g_lane
      localparam int LO = gi * MASK_GRAN;
      localparam int HI = ((gi + 1) * MASK_GRAN > DATA_WIDTH) ? (DATA_WIDTH - 1)
                                                              : ((gi + 1) * MASK_GRAN - 1);

      logic [HI-LO:0] lane_mem [DEPTH];
      logic           lane_we;
      logic [HI-LO:0] lane_wdata;
      logic           lane_fwd;

      assign lane_we    = !idle || (wr_ok && inst_wr_mask[gi]);
      assign lane_wdata = idle ? inst_wr_data[HI:LO] : '0;
      // write-first only forwards lanes that this cycle's write actually touches
      assign lane_fwd   = (BYPASS != 0) && hit && inst_wr_mask[gi];

      // lane write port; array is never reset, the fill clears it instead
      always_ff @(posedge inst_clk) begin
        if (lane_we) begin
          lane_mem[mem_idx] <= lane_wdata;
        end
      end

      assign rd_word[HI:LO] = !rd_in_range ? '0
                            : (lane_fwd ? inst_wr_data[HI:LO] : lane_mem[rd_idx]);
    end
  endgenerate

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (RD_LATENCY)
  ) u_rd_pipe (
    .inst_clk   (inst_clk),
    .inst_rst_n (inst_rst_n),
    .rd_vld     (rd_ok),
    .rd_data    (rd_word),
    .pipe_vld   (data_out_vld),
    .pipe_data  (data_out_inst)
  );

endmodule

// File: tb/tb_sram_model_2p.sv
// Bench for sram_model_2p: two instances share one stimulus stream
// (A: DEPTH 64, latency 3, write-first; B: DEPTH 50, latency 1, read-first)
// and are compared every cycle against a per-instance reference model.
module tb_sram_model_2p;

  localparam int DW = 518;
  localparam int AW = 6;
  localparam int MW = (DW + 7) / 8;

  logic           inst_clk = 1'b0;
  logic           inst_rst_n = 1'b0;
  logic           inst_wr_cs_n = 1'b1;
  logic [AW-1:0]  inst_wr_addr = '0;
  logic [DW-1:0]  inst_wr_data = '0;
  logic [MW-1:0]  inst_wr_mask = '0;
  logic           inst_rd_cs_n = 1'b1;
  logic [AW-1:0]  inst_rd_addr = '0;
  logic           inst_init_start = 1'b0;

  logic [DW-1:0]  dout_a, dout_b;
  logic           vld_a, vld_b, busy_a, busy_b;

  always #5 inst_clk = ~inst_clk;

  sram_model_2p #(.DATA_WIDTH(DW), .DEPTH(64), .ADDR_WIDTH(AW), .MASK_GRAN(8),
                  .RD_LATENCY(3), .BYPASS(1)) u_dut_a (
    .inst_clk(inst_clk), .inst_rst_n(inst_rst_n),
    .inst_wr_cs_n(inst_wr_cs_n), .inst_wr_addr(inst_wr_addr),
    .inst_wr_data(inst_wr_data), .inst_wr_mask(inst_wr_mask),
    .inst_rd_cs_n(inst_rd_cs_n), .inst_rd_addr(inst_rd_addr),
    .inst_init_start(inst_init_start),
    .data_out_inst(dout_a), .data_out_vld(vld_a), .init_busy(busy_a)
  );

  sram_model_2p #(.DATA_WIDTH(DW), .DEPTH(50), .ADDR_WIDTH(AW), .MASK_GRAN(8),
                  .RD_LATENCY(1), .BYPASS(0)) u_dut_b (
    .inst_clk(inst_clk), .inst_rst_n(inst_rst_n),
    .inst_wr_cs_n(inst_wr_cs_n), .inst_wr_addr(inst_wr_addr),
    .inst_wr_data(inst_wr_data), .inst_wr_mask(inst_wr_mask),
    .inst_rd_cs_n(inst_rd_cs_n), .inst_rd_addr(inst_rd_addr),
    .inst_init_start(inst_init_start),
    .data_out_inst(dout_b), .data_out_vld(vld_b), .init_busy(busy_b)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem        [2][64];
  int            m_busy       [2];
  logic          m_sched_vld  [2][8];
  logic [DW-1:0] m_sched_data [2][8];
  logic          m_vld        [2];
  logic [DW-1:0] m_data       [2];
  int            cyc;
  int            n_checks;
  int            n_errors;

  function automatic int m_depth(input int i); return (i == 0) ? 64 : 50; endfunction
  function automatic int m_lat(input int i);   return (i == 0) ? 3 : 1;   endfunction
  function automatic bit m_byp(input int i);   return (i == 0);           endfunction

  // Expand a lane mask into a per-bit enable (top lane is only 6 bits wide).
  function automatic logic [DW-1:0] lane_bits(input logic [MW-1:0] mask);
    logic [DW-1:0] bm;
    logic [MW-1:0] mm;
    bm = '0;
    mm = mask;
    for (int l = 0; l < MW; l++) begin
      if (mm[0]) bm = bm | (DW'(8'hFF) << (8 * l));
      mm = mm >> 1;
    end
    return bm;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = m_depth(i);
      m_vld[i]  = 1'b0;
      m_data[i] = '0;
      for (int s = 0; s < 8; s++) m_sched_vld[i][s] = 1'b0;
    end
  endtask

  // Apply one rising edge's worth of behaviour using the inputs now driven.
  task automatic model_edge();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int dep, s, wa, ra;
      logic wr_acc;
      logic [DW-1:0] v, bm;
      dep = m_depth(i);
      wa  = int'(inst_wr_addr);
      ra  = int'(inst_rd_addr);
      bm  = lane_bits(inst_wr_mask);
      if (m_busy[i] > 0) begin
        m_mem[i][dep - m_busy[i]] = '0;
        m_busy[i]--;
      end else begin
        wr_acc = !inst_wr_cs_n && (wa < dep);
        if (!inst_rd_cs_n) begin
          v = (ra < dep) ? m_mem[i][ra] : '0;
          if (m_byp(i) && wr_acc && (wa == ra)) v = (v & ~bm) | (inst_wr_data & bm);
          s = (cyc + m_lat(i) - 1) % 8;
          m_sched_vld[i][s]  = 1'b1;
          m_sched_data[i][s] = v;
        end
        if (wr_acc) m_mem[i][wa] = (m_mem[i][wa] & ~bm) | (inst_wr_data & bm);
        if (inst_init_start) m_busy[i] = dep;
      end
      s = cyc % 8;
      if (m_sched_vld[i][s]) begin
        m_vld[i]  = 1'b1;
        m_data[i] = m_sched_data[i][s];
        m_sched_vld[i][s] = 1'b0;
      end else begin
        m_vld[i] = 1'b0;
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge inst_clk);
    if (inst_rst_n) model_edge();
    @(negedge inst_clk);
    chk("a_busy", DW'(busy_a), DW'(m_busy[0] > 0));
    chk("b_busy", DW'(busy_b), DW'(m_busy[1] > 0));
    chk("a_vld",  DW'(vld_a),  DW'(m_vld[0]));
    chk("b_vld",  DW'(vld_b),  DW'(m_vld[1]));
    chk("a_data", dout_a, m_data[0]);
    chk("b_data", dout_b, m_data[1]);
  endtask

  task automatic txn(input logic we, input int wa, input logic [DW-1:0] wd,
                     input logic [MW-1:0] wm, input logic re, input int ra);
    inst_wr_cs_n = !we;
    inst_wr_addr = AW'(wa);
    inst_wr_data = wd;
    inst_wr_mask = wm;
    inst_rd_cs_n = !re;
    inst_rd_addr = AW'(ra);
    $display("txn cyc=%0d wr=%0b waddr=%0d wdata=%0h rd=%0b raddr=%0d", cyc, we, wa, wd[31:0], re, ra);
    step();
    inst_wr_cs_n = 1'b1;
    inst_rd_cs_n = 1'b1;
  endtask

  // Called right after a read transaction: B shows it now, A two cycles later.
  task automatic expect_read(input string tag, input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b);
    chk({tag, "_b_vld"}, DW'(vld_b), DW'(1));
    chk({tag, "_b_data"}, dout_b, exp_b);
    step();
    chk({tag, "_a_early"}, DW'(vld_a), DW'(0));
    step();
    chk({tag, "_a_vld"}, DW'(vld_a), DW'(1));
    chk({tag, "_a_data"}, dout_a, exp_a);
    step();
  endtask

  task automatic measure_fill(input string tag);
    int na, nb, guard;
    na = 0; nb = 0; guard = 0;
    while ((busy_a || busy_b) && guard < 200) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      step();
      guard++;
    end
    chk({tag, "_a_len"}, DW'(na), DW'(64));
    chk({tag, "_b_len"}, DW'(nb), DW'(50));
  endtask

  initial begin
    logic [DW-1:0] full_d;
    logic [MW-1:0] full_m;
    full_m   = '1;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    model_reset();
    repeat (3) step();
    chk("rst_a_busy", DW'(busy_a), DW'(1));
    chk("rst_a_data", dout_a, '0);
    inst_rst_n = 1'b1;
    measure_fill("fill1");

    txn(1'b0, 0, '0, '0, 1'b1, 5);
    expect_read("rd5", '0, '0);

    txn(1'b1, 3, 518'hAA, full_m, 1'b0, 0);
    txn(1'b0, 0, '0, '0, 1'b1, 3);
    expect_read("wr3", 518'hAA, 518'hAA);

    txn(1'b1, 10, 518'h1234, full_m, 1'b0, 0);
    txn(1'b1, 10, 518'hFF, MW'(1), 1'b0, 0);
    txn(1'b0, 0, '0, '0, 1'b1, 10);
    expect_read("mask", 518'h12FF, 518'h12FF);

    txn(1'b1, 7, 518'h11, full_m, 1'b0, 0);
    txn(1'b1, 7, 518'h22, full_m, 1'b1, 7);
    expect_read("coll", 518'h22, 518'h11);
    txn(1'b0, 0, '0, '0, 1'b1, 7);
    expect_read("coll2", 518'h22, 518'h22);

    txn(1'b1, 60, 518'h55, full_m, 1'b0, 0);
    txn(1'b0, 0, '0, '0, 1'b1, 60);
    expect_read("oor60", 518'h55, '0);
    txn(1'b0, 0, '0, '0, 1'b1, 28);
    expect_read("oor28", '0, '0);

    // leave non-zero data on the outputs, restart the fill, reset mid-fill
    txn(1'b0, 0, '0, '0, 1'b1, 3);
    expect_read("pre", 518'hAA, 518'hAA);
    inst_init_start = 1'b1;
    $display("txn cyc=%0d init_start", cyc);
    step();
    inst_init_start = 1'b0;
    repeat (20) step();
    chk("held_a_data", dout_a, 518'hAA);
    inst_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst20_a_data", dout_a, '0);
    chk("rst20_b_data", dout_b, '0);
    chk("rst20_a_vld", DW'(vld_a), DW'(0));
    chk("rst20_a_busy", DW'(busy_a), DW'(1));
    chk("rst20_b_busy", DW'(busy_b), DW'(1));
    repeat (2) step();
    inst_rst_n = 1'b1;
    measure_fill("fill2");

    // randomized traffic, clustered on a few addresses to provoke collisions
    for (int n = 0; n < 600; n++) begin
      full_d = '0;
      for (int k = 0; k < 17; k++) full_d = (full_d << 32) | DW'($urandom);
      inst_wr_cs_n    = ($urandom_range(0, 2) == 0);
      inst_wr_addr    = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
      inst_wr_data    = full_d;
      inst_wr_mask    = ($urandom_range(0, 3) == 0) ? full_m : MW'({$urandom, $urandom, $urandom});
      inst_rd_cs_n    = ($urandom_range(0, 2) == 0);
      inst_rd_addr    = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
      inst_init_start = ($urandom_range(0, 299) == 0);
      $display("rnd cyc=%0d wr=%0b/%0d rd=%0b/%0d init=%0b", cyc, !inst_wr_cs_n, inst_wr_addr,
               !inst_rd_cs_n, inst_rd_addr, inst_init_start);
      step();
    end
    inst_wr_cs_n    = 1'b1;
    inst_rd_cs_n    = 1'b1;
    inst_init_start = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
